lc3_mc_core: RTL and testbench

Multi-cycle LC-3 execution core that generalises the first-generation LC-3 top into a complete fetch/decode/execute sequencer. It has a parametrised memory address width and a variable-latency memory request/ready handshake. It integrates R0–R7, the N/Z/P condition codes, and a register debug port for the board display. It sits between the board top level (switches/LEDs) and a word-addressed memory block.

---
 rtl/lc3_pkg.sv | 40 ++++
 rtl/lc3_regfile_p.sv | 32 +++
 rtl/lc3_mc_core.sv | 156 +++++++++++++++
 tb/tb_lc3_mc_core.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 core definitions: opcodes, sequencer states, condition codes and field helpers.
package lc3_pkg;

   localparam int unsigned XLEN = 16;

   localparam logic [3:0] OP_BR   = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_LD   = 4'b0010;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_NOT  = 4'b1001;
   localparam logic [3:0] OP_LEA  = 4'b1110;
   localparam logic [3:0] OP_TRAP = 4'b1111;

   localparam logic [2:0] CC_N = 3'b100;
   localparam logic [2:0] CC_Z = 3'b010;
   localparam logic [2:0] CC_P = 3'b001;

   localparam logic [7:0] TRAP_HALT = 8'h25;

   typedef enum logic [2:0] {
      FETCH, DECODE, EVADD, MEMRD, MEMWR, EXEC, HALT
   } state_t;

   function automatic logic [XLEN-1:0] sext5(input logic [4:0] v);
      return {{11{v[4]}}, v};
   endfunction

   function automatic logic [XLEN-1:0] sext9(input logic [8:0] v);
      return {{7{v[8]}}, v};
   endfunction

   // Exactly one of N/Z/P is produced for any result.
   function automatic logic [2:0] cc_of(input logic [XLEN-1:0] r);
      if (r[XLEN-1])     return CC_N;
      else if (r == '0)  return CC_Z;
      else               return CC_P;
   endfunction

endpackage

// File: rtl/lc3_regfile_p.sv
// R0-R7: two async read ports, one debug read port, one synchronous write port.
module lc3_regfile_p
   import lc3_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [2:0]      waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [2:0]      ra_a,
   input  logic [2:0]      ra_b,
   input  logic [2:0]      dbg_sel,
   output logic [XLEN-1:0] rd_a,
   output logic [XLEN-1:0] rd_b,
   output logic [XLEN-1:0] dbg_reg
);

   logic [XLEN-1:0] regs [8];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rd_a    = regs[ra_a];
   assign rd_b    = regs[ra_b];
   assign dbg_reg = regs[dbg_sel];

endmodule

// File: rtl/lc3_mc_core.sv
// Multi-cycle LC-3 sequencer with a request/ready memory port and register debug tap.
module lc3_mc_core
   import lc3_pkg::*;
#(
   parameter int unsigned ADDR_W   = 7,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic [15:0]       mem_rdata,
   input  logic              mem_ready,
   input  logic [2:0]        dbg_sel,
   output logic [15:0]       dbg_reg,
   output logic [2:0]        cc,
   output logic [15:0]       pc,
   output logic              halted,
   output logic              illegal
);

   state_t            state, state_d;
   logic [15:0]       pc_r, pc_d, ir, ir_d;
   logic [ADDR_W-1:0] mar, mar_d;
   logic [2:0]        cc_r, cc_d;
   logic              illegal_r, illegal_d;

   logic              rf_we;
   logic [15:0]       rf_wdata, rd_a, rd_b, op_b, pc_off, alu_res;
   logic [3:0]        opcode;
   logic [2:0]        ra_b;

   assign opcode = ir[15:12];
   // Port B doubles as the store-data source while a write is outstanding.
   assign ra_b   = (state == MEMWR) ? ir[11:9] : ir[2:0];

   lc3_regfile_p u_rf (
      .clk     (clk),
      .rst     (rst),
      .we      (rf_we),
      .waddr   (ir[11:9]),
      .wdata   (rf_wdata),
      .ra_a    (ir[8:6]),
      .ra_b    (ra_b),
      .dbg_sel (dbg_sel),
      .rd_a    (rd_a),
      .rd_b    (rd_b),
      .dbg_reg (dbg_reg)
   );

   assign op_b   = ir[5] ? sext5(ir[4:0]) : rd_b;
   assign pc_off = pc_r + sext9(ir[8:0]);

   // Inline ALU; LEA shares the result path so CC logic stays common.
   always_comb begin
      alu_res = '0;
      case (opcode)
         OP_ADD:  alu_res = rd_a + op_b;
         OP_AND:  alu_res = rd_a & op_b;
         OP_NOT:  alu_res = ~rd_a;
         OP_LEA:  alu_res = pc_off;
         default: alu_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FETCH;
         pc_r      <= RESET_PC;
         ir        <= '0;
         mar       <= '0;
         cc_r      <= CC_Z;
         illegal_r <= 1'b0;
      end else begin
         state     <= state_d;
         pc_r      <= pc_d;
         ir        <= ir_d;
         mar       <= mar_d;
         cc_r      <= cc_d;
         illegal_r <= illegal_d;
      end
   end

   always_comb begin
      state_d   = state;
      pc_d      = pc_r;
      ir_d      = ir;
      mar_d     = mar;
      cc_d      = cc_r;
      illegal_d = illegal_r;
      rf_we     = 1'b0;
      rf_wdata  = alu_res;
      case (state)
         FETCH: begin
            if (mem_ready) begin
               ir_d    = mem_rdata;
               pc_d    = pc_r + 16'd1;
               state_d = DECODE;
            end
         end
         DECODE: begin
            case (opcode)
               OP_ADD, OP_AND, OP_NOT, OP_BR, OP_LEA: state_d = EXEC;
               OP_LD, OP_ST:                          state_d = EVADD;
               OP_TRAP: begin
                  state_d   = HALT;
                  illegal_d = (ir[7:0] != TRAP_HALT);
               end
               default: begin
                  state_d   = HALT;
                  illegal_d = 1'b1;
               end
            endcase
         end
         EVADD: begin
            mar_d   = ADDR_W'(pc_off);
            state_d = (opcode == OP_LD) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            if (mem_ready) begin
               rf_we    = 1'b1;
               rf_wdata = mem_rdata;
               cc_d     = cc_of(mem_rdata);
               state_d  = FETCH;
            end
         end
         MEMWR: begin
            if (mem_ready) state_d = FETCH;
         end
         EXEC: begin
            if (opcode == OP_BR) begin
               if ((ir[11:9] & cc_r) != 3'b000) pc_d = pc_off;
            end else begin
               rf_we = 1'b1;
               cc_d  = cc_of(alu_res);
            end
            state_d = FETCH;
         end
         HALT:    state_d = HALT;
         default: state_d = FETCH;
      endcase
   end

   assign mem_req   = !rst && (state == FETCH || state == MEMRD || state == MEMWR);
   assign mem_we    = !rst && (state == MEMWR);
   assign mem_addr  = (state == FETCH) ? pc_r[ADDR_W-1:0] : mar;
   assign mem_wdata = rd_b;

   assign cc      = cc_r;
   assign pc      = pc_r;
   assign halted  = (state == HALT);
   assign illegal = illegal_r;

endmodule

// File: tb/tb_lc3_mc_core.sv
// Directed bench for lc3_mc_core with a word memory model and selectable ready pacing.
module tb_lc3_mc_core;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_req, mem_we, mem_ready, halted, illegal;
   logic [6:0]  mem_addr;
   logic [15:0] mem_wdata, mem_rdata, dbg_reg, pc;
   logic [2:0]  dbg_sel = 3'd0;
   logic [2:0]  cc;

   logic [15:0] tb_mem [128];
   int          ready_mode = 0;
   logic [1:0]  rcnt = 2'd0;
   int          wr_count = 0;
   int          checks = 0;
   int          errors = 0;
   logic        pend = 1'b0;
   logic [6:0]  p_addr;
   logic [15:0] p_wd;

   lc3_mc_core #(.ADDR_W(7), .RESET_PC(16'h0000)) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .dbg_sel   (dbg_sel),
      .dbg_reg   (dbg_reg),
      .cc        (cc),
      .pc        (pc),
      .halted    (halted),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   // ready_mode: 0 = always ready, 1 = ready every third cycle
   assign mem_ready = (ready_mode == 0) ? 1'b1 : (rcnt == 2'd2);
   assign mem_rdata = tb_mem[mem_addr];

   always @(posedge clk) rcnt <= (rcnt == 2'd2) ? 2'd0 : rcnt + 2'd1;

   // Memory write model plus hold-stability check of a stalled write.
   always @(posedge clk) begin
      if (pend && mem_req && mem_we) begin
         checks++;
         if (mem_addr !== p_addr || mem_wdata !== p_wd) begin
            errors++;
            $display("FAIL write_stable: addr %h data %h, required addr %h data %h", mem_addr, mem_wdata, p_addr, p_wd);
         end
      end
      pend   = mem_req && mem_we && !mem_ready;
      p_addr = mem_addr;
      p_wd   = mem_wdata;
      if (mem_req && mem_we && mem_ready) begin
         tb_mem[mem_addr] = mem_wdata;
         wr_count++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   task automatic clear_mem();
      for (int i = 0; i < 128; i++) tb_mem[i] = 16'h0000;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      wr_count = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_halt(input int max);
      int n = 0;
      while (!halted && n < max) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (halted !== 1'b1) begin errors++; $display("FAIL halt_timeout: halted %b after %0d cycles, required 1", halted, n); end
   endtask

   task automatic test_reset();
      clear_mem();
      ready_mode = 0;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h required 0000", pc); end
      checks++; if (cc !== 3'b010) begin errors++; $display("FAIL reset_cc: got %b required 010", cc); end
      checks++; if (halted !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL reset_flags: halted %b illegal %b required 0 0", halted, illegal); end
      checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem: req %b we %b required 0 0", mem_req, mem_we); end
      for (int i = 0; i < 8; i++) begin
         dbg_sel = 3'(i);
         #1;
         checks++; if (dbg_reg !== 16'h0000) begin errors++; $display("FAIL reset_reg R%0d: got %h required 0000", i, dbg_reg); end
      end
      rst = 1'b0;
   endtask

   task automatic test_add_seq();
      clear_mem();
      tb_mem[0] = 16'h1225;   // ADD R1,R0,#5
      tb_mem[1] = 16'h147A;   // ADD R2,R1,#-6
      ready_mode = 0;
      do_reset();
      dbg_sel = 3'd1;
      step(2);
      checks++; if (dbg_reg !== 16'h0000) begin errors++; $display("FAIL add_early: R1 %h required 0000", dbg_reg); end
      step(1);
      checks++; if (dbg_reg !== 16'h0005) begin errors++; $display("FAIL add_r1: got %h required 0005", dbg_reg); end
      checks++; if (cc !== 3'b001) begin errors++; $display("FAIL add_cc_p: got %b required 001", cc); end
      step(3);
      dbg_sel = 3'd2;
      #1;
      checks++; if (dbg_reg !== 16'hFFFF) begin errors++; $display("FAIL add_r2: got %h required FFFF", dbg_reg); end
      checks++; if (cc !== 3'b100) begin errors++; $display("FAIL add_cc_n: got %b required 100", cc); end
      checks++; if (pc !== 16'h0002) begin errors++; $display("FAIL add_pc: got %h required 0002", pc); end
   endtask

   task automatic test_st_ld();
      clear_mem();
      tb_mem[0] = 16'h1225;   // ADD R1,R0,#5
      tb_mem[1] = 16'h147A;   // ADD R2,R1,#-6
      tb_mem[2] = 16'h3402;   // ST R2,#2  -> x05
      tb_mem[3] = 16'h2601;   // LD R3,#1  -> x05
      tb_mem[4] = 16'hF025;   // HALT
      ready_mode = 1;
      do_reset();
      wait_halt(300);
      checks++; if (tb_mem[5] !== 16'hFFFF) begin errors++; $display("FAIL st_data: mem[05] %h required FFFF", tb_mem[5]); end
      checks++; if (wr_count !== 1) begin errors++; $display("FAIL st_count: got %0d required 1", wr_count); end
      dbg_sel = 3'd3;
      #1;
      checks++; if (dbg_reg !== 16'hFFFF) begin errors++; $display("FAIL ld_r3: got %h required FFFF", dbg_reg); end
      checks++; if (cc !== 3'b100) begin errors++; $display("FAIL ld_cc: got %b required 100", cc); end
      checks++; if (illegal !== 1'b0 || pc !== 16'h0005) begin errors++; $display("FAIL ld_end: illegal %b pc %h required 0 0005", illegal, pc); end
      ready_mode = 0;
   endtask

   task automatic test_branch();
      logic [15:0] br_op [4];
      logic [15:0] br_pc [4];
      br_op[0] = 16'h05FE; br_pc[0] = 16'h0000;   // BRz -2, taken
      br_op[1] = 16'h09FE; br_pc[1] = 16'h0002;   // BRn -2, not taken
      br_op[2] = 16'h01FE; br_pc[2] = 16'h0002;   // nzp=000, never
      br_op[3] = 16'h0FFE; br_pc[3] = 16'h0000;   // nzp=111, always
      ready_mode = 0;
      for (int i = 0; i < 4; i++) begin
         clear_mem();
         tb_mem[0] = 16'h5920;   // AND R4,R4,#0
         tb_mem[1] = br_op[i];
         do_reset();
         step(3);
         checks++; if (cc !== 3'b010) begin errors++; $display("FAIL br_cc[%0d]: got %b required 010", i, cc); end
         step(3);
         checks++; if (pc !== br_pc[i]) begin errors++; $display("FAIL br_pc[%0d]: got %h required %h", i, pc, br_pc[i]); end
         step(1);
         checks++; if (pc !== br_pc[i] + 16'd1) begin errors++; $display("FAIL br_next[%0d]: got %h required %h", i, pc, br_pc[i] + 16'd1); end
      end
   endtask

   task automatic test_not_lea();
      clear_mem();
      tb_mem[0]  = 16'h9A3F;   // NOT R5,R0
      tb_mem[1]  = 16'h0E0E;   // BRnzp to x0010
      tb_mem[16] = 16'hEDFF;   // LEA R6,#-1
      tb_mem[17] = 16'hF025;   // HALT
      ready_mode = 0;
      do_reset();
      dbg_sel = 3'd5;
      step(3);
      checks++; if (dbg_reg !== 16'hFFFF) begin errors++; $display("FAIL not_r5: got %h required FFFF", dbg_reg); end
      checks++; if (cc !== 3'b100) begin errors++; $display("FAIL not_cc: got %b required 100", cc); end
      wait_halt(50);
      dbg_sel = 3'd6;
      #1;
      checks++; if (dbg_reg !== 16'h0010) begin errors++; $display("FAIL lea_r6: got %h required 0010", dbg_reg); end
      checks++; if (cc !== 3'b001) begin errors++; $display("FAIL lea_cc: got %b required 001", cc); end
      checks++; if (pc !== 16'h0012) begin errors++; $display("FAIL lea_pc: got %h required 0012", pc); end
   endtask

   task automatic test_halt();
      logic [15:0] bad [3];
      bad[0] = 16'hD000;   // reserved opcode
      bad[1] = 16'hF026;   // unsupported TRAP vector
      bad[2] = 16'h4000;   // JSR not supported
      clear_mem();
      tb_mem[0] = 16'hF025;
      ready_mode = 0;
      do_reset();
      step(1);
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL trap_early: halted %b required 0", halted); end
      wait_halt(10);
      checks++; if (illegal !== 1'b0 || pc !== 16'h0001) begin errors++; $display("FAIL trap_state: illegal %b pc %h required 0 0001", illegal, pc); end
      for (int i = 0; i < 4; i++) begin
         step(1);
         checks++; if (mem_req !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL halt_hold: req %b halted %b required 0 1", mem_req, halted); end
      end
      for (int i = 0; i < 3; i++) begin
         clear_mem();
         tb_mem[0] = bad[i];
         do_reset();
         wait_halt(10);
         checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal[%0d]: got %b required 1", i, illegal); end
      end
   endtask

   task automatic test_reset_mid_write();
      clear_mem();
      tb_mem[0] = 16'h1225;   // ADD R1,R0,#5
      tb_mem[1] = 16'h3205;   // ST R1,#5 -> x07
      ready_mode = 0;
      do_reset();
      step(6);
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 7'h07) begin errors++; $display("FAIL mw_setup: req %b we %b addr %h required 1 1 07", mem_req, mem_we, mem_addr); end
      rst = 1'b1;
      #1;
      checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL mw_gate: req %b we %b required 0 0", mem_req, mem_we); end
      @(negedge clk);
      rst = 1'b0;
      dbg_sel = 3'd1;
      #1;
      checks++; if (wr_count !== 0 || tb_mem[7] !== 16'h0000) begin errors++; $display("FAIL mw_abandon: writes %0d mem[07] %h required 0 0000", wr_count, tb_mem[7]); end
      checks++; if (pc !== 16'h0000 || cc !== 3'b010) begin errors++; $display("FAIL mw_pc_cc: pc %h cc %b required 0000 010", pc, cc); end
      checks++; if (halted !== 1'b0 || illegal !== 1'b0 || dbg_reg !== 16'h0000) begin errors++; $display("FAIL mw_state: halted %b illegal %b R1 %h required 0 0 0000", halted, illegal, dbg_reg); end
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 7'h00) begin errors++; $display("FAIL mw_fetch: req %b we %b addr %h required 1 0 00", mem_req, mem_we, mem_addr); end
      step(1);
      checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL mw_refetch: pc %h required 0001", pc); end
   endtask

   initial begin
      test_reset();
      test_add_seq();
      test_st_ld();
      test_branch();
      test_not_lea();
      test_halt();
      test_reset_mid_write();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
